gh_uart_rx_nbit: RTL and testbench
==================================

// Module: gh_uart_rx_nbit
// PURPOSE
//  Parametrised UART receiver; successor of the fixed 8-bit/16x Rx. Adds 5..MAX_BITS data bits,
//  5 parity modes, 1/2 stop bits, 3-sample majority vote with noise flag, and config latched per frame.
//  Sits behind the baud generator; feeds the Rx FIFO of the 16550-style UART.
// PARAMETERS
//  MAX_BITS    9   widest data word; num_bits above this saturates to MAX_BITS
//  OVERSAMPLE  16  brcx ticks per bit; even, >=8
//  SYNC_STAGES 2   srx synchroniser depth, >=2
// PORTS
//  clk          in   1         system clock
//  rst_n        in   1         synchronous reset, active low
//  brcx         in   1         oversample clock enable, 1 clk wide, OVERSAMPLE per bit
//  srx          in   1         async serial input, idle high
//  num_bits     in   4         data bits 5..MAX_BITS; <5 treated as 5
//  parity_mode  in   3         uart_pkg::parity_t: NONE, EVEN, ODD, MARK, SPACE
//  stop2        in   1         1 = check two stop bits
//  d            out  MAX_BITS  received word, LSB = first bit, right-justified, upper bits 0
//  d_rdy        out  1         1-clk pulse: d and flags valid
//  parity_er    out  1         parity mismatch, current frame
//  frame_er     out  1         any checked stop bit sampled 0
//  noise_er     out  1         any majority vote in the frame was not unanimous
//  break_itr    out  1         break: start+data+parity+stop all 0
// BEHAVIOUR
//  Clocking and reset
//  - Single clk; every flop changes only when brcx=1, except d_rdy clear and reset.
//  - rst_n=0 at a clk edge: state IDLE, synchroniser 1s.
//  - All outputs 0, except d=0.
//  - Reset mid-frame discards the frame; no d_rdy.
//  Sampling
//  - Tick counter tc counts 0..OVERSAMPLE-1 per bit.
//  - Samples taken at tc = M-1, M, M+1 (M = OVERSAMPLE/2).
//  - Bit value = majority; non-unanimous vote sets noise_er for the frame.
//  FSM
//  - IDLE: sync'd rx=0 -> START, tc=0.
//    num_bits, parity_mode and stop2 are latched here; mid-frame changes are ignored.
//  - START: at vote, bit=1 -> IDLE (false start, no flags, no d_rdy). At tc=OVERSAMPLE-1 -> DATA.
//  - DATA: shift voted bit into shift register MSB-first-in, so the LSB ends at bit 0 after num_bits.
//    Bit counter loads num_bits and decrements per bit; at 0 -> PARITY if mode!=NONE, else STOP.
//  - PARITY: EVEN = even total ones; ODD = odd; MARK expects 1; SPACE expects 0.
//    Mismatch sets parity_er.
//  - STOP: vote each stop bit; 0 sets frame_er. Frame completes at the last stop-bit vote (tc=M+1),
//    not at bit end, for early resync.
//    On completion: d, flags registered, d_rdy=1 for exactly one clk.
//    Then IDLE if rx=1; BREAK if break, else wait in IDLE.
//    A 0 line is re-detected as a new start on the next brcx.
//  - BREAK: break_itr=1 with d_rdy, d=0, frame_er=1. Stay until rx=1 for one full vote, then IDLE.
//    Exactly one d_rdy per break.
//  - Flags hold until the next d_rdy; they are all updated together at d_rdy.
//  - Latency: d_rdy is asserted M+2 brcx ticks after the start of the last stop bit on sync'd rx,
//    plus SYNC_STAGES brcx.
//  - Simultaneous: a d_rdy pulse and a new start in the same tick are both honoured.
// STRUCTURE
//  - uart_pkg: parity_t enum; UART_MIN_BITS=5.
//  - One sub-module: gh_uart_rx_sampler. It holds the synchroniser, tc counter, 3-sample majority and
//    noise bit, and outputs bit_strobe, bit_val, bit_noisy and bit_end. It is reusable by the Tx
//    loopback checker.
//  - FSM, shift register, parity accumulator and output registers live in the top.
// TESTING
//  1. 8N1, 0x55 at 16x, clean: d_rdy once, d=0x055, all flags 0.
//  2. 9 bits, EVEN, 2 stop, 0x1A3: d=0x1A3; a second frame with the parity bit flipped gives parity_er=1.
//  3. 5O1, 0x1F, stop bit forced 0: frame_er=1, d=0x01F; next good frame clears frame_er.
//  4. Start glitch 4 ticks low: no d_rdy, FSM back in IDLE.
//     Single-tick glitch inside a data bit: d correct, noise_er=1.
//  5. Line low for 2 frame times: exactly one d_rdy, break_itr=1, d=0.
//     After rx high, 7E1 0x41 is received cleanly with break_itr=0.
//  6. rst_n low mid-DATA, then release: outputs 0, no d_rdy.
//     Following 8N1 0xA5 received correctly; num_bits changed mid-frame has no effect.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam int UART_MIN_BITS = 5;

    // Clamp a requested word length into UART_MIN_BITS..max_bits.
    function automatic logic [3:0] clamp_bits(input logic [3:0] nb, input int max_bits);
        if (int'(nb) < UART_MIN_BITS) begin
            return 4'(UART_MIN_BITS);
        end else if (int'(nb) > max_bits) begin
            return 4'(max_bits);
        end else begin
            return nb;
        end
    endfunction

    // True when the frame carries a parity bit (unknown encodings act as NONE).
    function automatic logic has_parity(input parity_t mode);
        case (mode)
            PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // acc is the XOR of all data bits; b is the received parity bit.
    function automatic logic parity_fail(input parity_t mode, input logic acc, input logic b);
        case (mode)
            PAR_EVEN:  return acc ^ b;
            PAR_ODD:   return ~(acc ^ b);
            PAR_MARK:  return ~b;
            PAR_SPACE: return b;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gh_uart_rx_sampler.sv
// Line synchroniser, per-bit tick counter and 3-sample majority voter.
// Reusable by any block that needs voted bits from an oversampled serial line.
module gh_uart_rx_sampler #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic brcx,
    input  logic srx,
    input  logic run,        // a frame (or break) is being tracked
    input  logic start,      // this brcx is tick 0 of a new start bit
    output logic rx,         // synchronised line
    output logic bit_strobe, // vote available this brcx
    output logic bit_val,
    output logic bit_noisy,
    output logic bit_end     // last tick of the bit
);

    localparam int TC_W = $clog2(OVERSAMPLE);
    localparam int M    = OVERSAMPLE / 2;
    localparam logic [TC_W-1:0] TC_S0   = TC_W'(M - 1);
    localparam logic [TC_W-1:0] TC_S1   = TC_W'(M);
    localparam logic [TC_W-1:0] TC_VOTE = TC_W'(M + 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TC_W-1:0]        tc_q, tc_d;
    logic                   s0_q, s0_d;
    logic                   s1_q, s1_d;

    assign rx = sync_q[SYNC_STAGES-1];

    // Next-state for synchroniser, tick counter and the two early samples.
    always_comb begin
        sync_d = sync_q;
        tc_d   = tc_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        if (brcx) begin
            sync_d = {sync_q[SYNC_STAGES-2:0], srx};
            // The detecting tick is tick 0, so the next one is tick 1.
            if (start) begin
                tc_d = TC_W'(1);
            end else if (run) begin
                tc_d = (tc_q == TC_LAST) ? '0 : tc_q + 1'b1;
            end else begin
                tc_d = '0;
            end
            if (run && tc_q == TC_S0) s0_d = rx;
            if (run && tc_q == TC_S1) s1_d = rx;
        end
    end

    // Vote uses the two stored samples plus the live line as the third.
    always_comb begin
        bit_strobe = brcx && run && (tc_q == TC_VOTE);
        bit_end    = brcx && run && (tc_q == TC_LAST);
        bit_val    = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
        bit_noisy  = !((s0_q & s1_q & rx) | (!s0_q & !s1_q & !rx));
    end

    // Sampler state registers; synchroniser resets to the idle (high) line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            tc_q   <= '0;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else begin
            sync_q <= sync_d;
            tc_q   <= tc_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
        end
    end

endmodule

// File: rtl/gh_uart_rx_nbit.sv
// Parametrised UART receiver: 5..MAX_BITS data bits, five parity modes,
// one or two stop bits, majority-voted sampling with noise and break detection.
module gh_uart_rx_nbit
    import uart_pkg::*;
#(
    parameter int MAX_BITS    = 9,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                brcx,
    input  logic                srx,
    input  logic [3:0]          num_bits,
    input  logic [2:0]          parity_mode,
    input  logic                stop2,
    output logic [MAX_BITS-1:0] d,
    output logic                d_rdy,
    output logic                parity_er,
    output logic                frame_er,
    output logic                noise_er,
    output logic                break_itr
);

    logic rx, bit_strobe, bit_val, bit_noisy, bit_end;
    logic frame_start;
    logic run;

    rx_state_t           state_q, state_d;
    logic [3:0]          nbits_q, nbits_d;
    parity_t             par_q, par_d;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic                stops_left_q, stops_left_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic                par_acc_q, par_acc_d;
    logic                par_err_q, par_err_d;
    logic                frm_err_q, frm_err_d;
    logic                noise_q, noise_d;
    logic                any_one_q, any_one_d;

    logic [MAX_BITS-1:0] d_q, d_d;
    logic                d_rdy_q, d_rdy_d;
    logic                parity_er_q, parity_er_d;
    logic                frame_er_q, frame_er_d;
    logic                noise_er_q, noise_er_d;
    logic                break_q, break_d;

    logic                brk;
    logic [3:0]          shamt;

    assign run = (state_q != ST_IDLE);

    gh_uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .brcx      (brcx),
        .srx       (srx),
        .run       (run),
        .start     (frame_start),
        .rx        (rx),
        .bit_strobe(bit_strobe),
        .bit_val   (bit_val),
        .bit_noisy (bit_noisy),
        .bit_end   (bit_end)
    );

    // Frame FSM: next state, shift/parity accumulation and output capture.
    always_comb begin
        state_d      = state_q;
        nbits_d      = nbits_q;
        par_d        = par_q;
        bitcnt_d     = bitcnt_q;
        stops_left_d = stops_left_q;
        shift_d      = shift_q;
        par_acc_d    = par_acc_q;
        par_err_d    = par_err_q;
        frm_err_d    = frm_err_q;
        noise_d      = noise_q;
        any_one_d    = any_one_q;
        d_d          = d_q;
        d_rdy_d      = 1'b0;   // pulse lasts one clk regardless of brcx
        parity_er_d  = parity_er_q;
        frame_er_d   = frame_er_q;
        noise_er_d   = noise_er_q;
        break_d      = break_q;
        frame_start  = 1'b0;
        brk          = 1'b0;
        shamt        = 4'(MAX_BITS) - nbits_q;

        if (brcx) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx) begin
                        // Configuration is frozen for the whole frame here.
                        frame_start  = 1'b1;
                        state_d      = ST_START;
                        nbits_d      = clamp_bits(num_bits, MAX_BITS);
                        bitcnt_d     = clamp_bits(num_bits, MAX_BITS);
                        par_d        = parity_t'(parity_mode);
                        stops_left_d = stop2;
                        shift_d      = '0;
                        par_acc_d    = 1'b0;
                        par_err_d    = 1'b0;
                        frm_err_d    = 1'b0;
                        noise_d      = 1'b0;
                        any_one_d    = 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_strobe) begin
                        noise_d = noise_q | bit_noisy;
                        if (bit_val) state_d = ST_IDLE;   // false start, silently dropped
                    end
                    if (bit_end) state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_strobe) begin
                        shift_d   = {bit_val, shift_q[MAX_BITS-1:1]};
                        par_acc_d = par_acc_q ^ bit_val;
                        noise_d   = noise_q | bit_noisy;
                        any_one_d = any_one_q | bit_val;
                        bitcnt_d  = bitcnt_q - 4'd1;
                    end
                    if (bit_end && bitcnt_q == 4'd0) begin
                        state_d = has_parity(par_q) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (bit_strobe) begin
                        par_err_d = parity_fail(par_q, par_acc_q, bit_val);
                        noise_d   = noise_q | bit_noisy;
                        any_one_d = any_one_q | bit_val;
                    end
                    if (bit_end) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (bit_strobe) begin
                        frm_err_d = frm_err_q | !bit_val;
                        noise_d   = noise_q | bit_noisy;
                        any_one_d = any_one_q | bit_val;
                        if (stops_left_q) begin
                            stops_left_d = 1'b0;
                        end else begin
                            // Complete at the vote, not at bit end, to resync early.
                            brk         = !(any_one_q | bit_val);
                            d_d         = brk ? '0 : (shift_q >> shamt);
                            d_rdy_d     = 1'b1;
                            parity_er_d = par_err_q;
                            frame_er_d  = frm_err_q | !bit_val;
                            noise_er_d  = noise_q | bit_noisy;
                            break_d     = brk;
                            state_d     = brk ? ST_BREAK : ST_IDLE;
                        end
                    end
                end
                ST_BREAK: begin
                    if (bit_strobe && bit_val) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Frame and output registers; reset discards any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            nbits_q      <= 4'(UART_MIN_BITS);
            par_q        <= PAR_NONE;
            bitcnt_q     <= '0;
            stops_left_q <= 1'b0;
            par_acc_q    <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            noise_q      <= 1'b0;
            any_one_q    <= 1'b0;
            d_q          <= '0;
            d_rdy_q      <= 1'b0;
            parity_er_q  <= 1'b0;
            frame_er_q   <= 1'b0;
            noise_er_q   <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            nbits_q      <= nbits_d;
            par_q        <= par_d;
            bitcnt_q     <= bitcnt_d;
            stops_left_q <= stops_left_d;
            par_acc_q    <= par_acc_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            noise_q      <= noise_d;
            any_one_q    <= any_one_d;
            d_q          <= d_d;
            d_rdy_q      <= d_rdy_d;
            parity_er_q  <= parity_er_d;
            frame_er_q   <= frame_er_d;
            noise_er_q   <= noise_er_d;
            break_q      <= break_d;
        end
    end

    // Shift register is cleared at every start, so it needs no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign d         = d_q;
    assign d_rdy     = d_rdy_q;
    assign parity_er = parity_er_q;
    assign frame_er  = frame_er_q;
    assign noise_er  = noise_er_q;
    assign break_itr = break_q;

endmodule

// File: tb/tb_gh_uart_rx_nbit.sv
// Scoreboard bench for gh_uart_rx_nbit at 16x oversampling, brcx every other clk.
module tb_gh_uart_rx_nbit;
    import uart_pkg::*;

    localparam int MAX_BITS = 9;
    localparam int OS       = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                brcx = 1'b0;
    logic                brcx_div = 1'b0;
    logic                srx = 1'b1;
    logic [3:0]          num_bits = 4'd8;
    logic [2:0]          parity_mode = 3'd0;
    logic                stop2 = 1'b0;
    logic [MAX_BITS-1:0] d;
    logic                d_rdy, parity_er, frame_er, noise_er, break_itr;

    typedef struct {
        logic [MAX_BITS-1:0] d;
        logic                pe;
        logic                fe;
        logic                ne;
        logic                bi;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   rdy_cnt  = 0;
    int   n_pushed = 0;
    int   r0;

    gh_uart_rx_nbit #(.MAX_BITS(MAX_BITS), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .brcx       (brcx),
        .srx        (srx),
        .num_bits   (num_bits),
        .parity_mode(parity_mode),
        .stop2      (stop2),
        .d          (d),
        .d_rdy      (d_rdy),
        .parity_er  (parity_er),
        .frame_er   (frame_er),
        .noise_er   (noise_er),
        .break_itr  (break_itr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        brcx_div <= ~brcx_div;
        brcx     <= brcx_div;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Compare every d_rdy against the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (d_rdy === 1'b1) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_d_rdy", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("d", 32'(d), 32'(e.d));
                chk("parity_er", 32'(parity_er), 32'(e.pe));
                chk("frame_er", 32'(frame_er), 32'(e.fe));
                chk("noise_er", 32'(noise_er), 32'(e.ne));
                chk("break_itr", 32'(break_itr), 32'(e.bi));
            end
        end
    end

    // Returns at the negedge just before a brcx edge; srx set now is seen there.
    task automatic tick();
        do @(negedge clk); while (brcx !== 1'b1);
    endtask

    task automatic send_bit(input logic v, input int glitch_at);
        for (int k = 0; k < OS; k++) begin
            tick();
            srx = (k == glitch_at) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [MAX_BITS-1:0] data, input int nb, input parity_t pm,
                              input logic s2, input logic flip_par, input logic stop0,
                              input int glitch_bit, input int mid_nb);
        exp_t                e;
        logic [MAX_BITS-1:0] dm;
        logic                pbit;
        dm = '0;
        for (int i = 0; i < nb; i++) dm[i] = data[i];
        e.d  = dm;
        e.pe = flip_par;
        e.fe = stop0;
        e.ne = (glitch_bit >= 0);
        e.bi = 1'b0;
        sb.push_back(e);
        n_pushed++;
        num_bits    = 4'(nb);
        parity_mode = pm;
        stop2       = s2;
        send_bit(1'b0, -1);
        if (mid_nb > 0) num_bits = 4'(mid_nb);
        for (int i = 0; i < nb; i++) send_bit(dm[i], (i == glitch_bit) ? 8 : -1);
        if (pm != PAR_NONE) begin
            case (pm)
                PAR_EVEN: pbit = ^dm;
                PAR_ODD:  pbit = ~^dm;
                PAR_MARK: pbit = 1'b1;
                default:  pbit = 1'b0;
            endcase
            send_bit(pbit ^ flip_par, -1);
        end
        send_bit(~stop0, -1);
        if (s2) send_bit(1'b1, -1);
        send_bit(1'b1, -1);
    endtask

    initial begin
        exp_t eb;
        repeat (4) @(negedge clk);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_d_rdy", 32'(d_rdy), 32'd0);
        chk("rst_parity_er", 32'(parity_er), 32'd0);
        chk("rst_frame_er", 32'(frame_er), 32'd0);
        chk("rst_noise_er", 32'(noise_er), 32'd0);
        chk("rst_break_itr", 32'(break_itr), 32'd0);
        rst_n = 1'b1;
        send_bit(1'b1, -1);

        // 8N1 clean
        r0 = rdy_cnt;
        send_frame(9'h055, 8, PAR_NONE, 1'b0, 1'b0, 1'b0, -1, 0);
        chk("t1_rdy_count", 32'(rdy_cnt - r0), 32'd1);

        // 9E2, good then bad parity
        send_frame(9'h1A3, 9, PAR_EVEN, 1'b1, 1'b0, 1'b0, -1, 0);
        send_frame(9'h1A3, 9, PAR_EVEN, 1'b1, 1'b1, 1'b0, -1, 0);

        // 5O1 with zero stop bit, then a good frame
        send_frame(9'h01F, 5, PAR_ODD, 1'b0, 1'b0, 1'b1, -1, 0);
        send_frame(9'h00A, 5, PAR_ODD, 1'b0, 1'b0, 1'b0, -1, 0);

        // short start glitch
        r0 = rdy_cnt;
        for (int k = 0; k < 4; k++) begin
            tick();
            srx = 1'b0;
        end
        for (int k = 0; k < 2 * OS; k++) begin
            tick();
            srx = 1'b1;
        end
        chk("t4_glitch_no_rdy", 32'(rdy_cnt - r0), 32'd0);
        chk("t4_glitch_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // data-bit glitch: value still right, noise flagged
        send_frame(9'h03C, 8, PAR_NONE, 1'b0, 1'b0, 1'b0, 2, 0);

        // break: line low for two 8N1 frame times
        num_bits    = 4'd8;
        parity_mode = PAR_NONE;
        stop2       = 1'b0;
        eb.d  = '0;
        eb.pe = 1'b0;
        eb.fe = 1'b1;
        eb.ne = 1'b0;
        eb.bi = 1'b1;
        sb.push_back(eb);
        n_pushed++;
        r0 = rdy_cnt;
        for (int k = 0; k < 20 * OS; k++) begin
            tick();
            srx = 1'b0;
        end
        for (int k = 0; k < 2 * OS; k++) begin
            tick();
            srx = 1'b1;
        end
        chk("t5_break_one_rdy", 32'(rdy_cnt - r0), 32'd1);
        chk("t5_break_hold", 32'(break_itr), 32'd1);
        send_frame(9'h041, 7, PAR_EVEN, 1'b0, 1'b0, 1'b0, -1, 0);

        // reset in the middle of DATA
        r0 = rdy_cnt;
        num_bits = 4'd8;
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_rst_d", 32'(d), 32'd0);
        chk("t6_rst_d_rdy", 32'(d_rdy), 32'd0);
        chk("t6_rst_flags", 32'({parity_er, frame_er, noise_er, break_itr}), 32'd0);
        rst_n = 1'b1;
        srx   = 1'b1;
        for (int k = 0; k < 3; k++) send_bit(1'b1, -1);
        chk("t6_no_rdy", 32'(rdy_cnt - r0), 32'd0);
        send_frame(9'h0A5, 8, PAR_NONE, 1'b0, 1'b0, 1'b0, -1, 5);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("rdy_total", 32'(rdy_cnt), 32'(n_pushed));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
